// File: rtl/dma_copy.sv
// Word-copy DMA initiator: moves len 32-bit words from src_addr to dst_addr
// as read/write pairs on an arbitrated shared memory bus.
module dma_copy #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    inout  wire  [31:0]      mem_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD,
        S_WR,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [LEN_W-1:0] count;
    logic [31:0]      hold;
    logic             cmd_misaligned;

    assign cmd_misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (cmd_misaligned)
                        state_nxt = S_ERR;
                    else if (len == '0)
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_gnt)
                    state_nxt = S_RD;
            end
            S_RD: state_nxt = S_WR;
            S_WR: begin
                // Grant is re-sampled here so back-to-back pairs skip REQ
                if (count == LEN_W'(1))
                    state_nxt = S_DONE;
                else if (bus_gnt)
                    state_nxt = S_RD;
                else
                    state_nxt = S_REQ;
            end
            S_DONE: state_nxt = S_IDLE;
            S_ERR:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            src_ptr <= '0;
            dst_ptr <= '0;
            count   <= '0;
            hold    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (state_nxt == S_REQ) begin
                        src_ptr <= src_addr;
                        dst_ptr <= dst_addr;
                        count   <= len;
                    end
                end
                S_RD: hold <= mem_data;
                S_WR: begin
                    src_ptr <= src_ptr + 32'd4;
                    dst_ptr <= dst_ptr + 32'd4;
                    count   <= count - LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Every bus output decodes the state register alone, so the data driver
    // can never overlap with a responder during RD.
    always_comb begin
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        err      = (state == S_ERR);
        bus_req  = (state == S_REQ) || (state == S_RD) || (state == S_WR);
        mem_we   = (state == S_WR);
        mem_addr = '0;
        if (state == S_RD)
            mem_addr = src_ptr;
        else if (state == S_WR)
            mem_addr = dst_ptr;
    end

    assign mem_data = (state == S_WR) ? hold : 32'bz;

endmodule

// File: doc/dma_copy.md
# dma_copy

Word-copy DMA initiator for the embedded SoC's shared memory bus. Memory peripherals on that bus respond combinationally to reads and commit writes on the clock edge. This block is the other end: it drives `mem_we`/`mem_addr`, owns `mem_data` during its write cycles, and moves `len` 32-bit words from `src_addr` to `dst_addr` as read/write pairs. It sits beside the core and takes the bus through a `bus_req`/`bus_gnt` arbiter.

## Interface
- `LEN_W`, 16: width of the word-count input and internal counter.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `start`  in  1  single-cycle command strobe; sampled only in IDLE.
- `src_addr`  in  32  byte address of first source word; latched on accepted `start`.
- `dst_addr`  in  32  byte address of first destination word; latched on accepted `start`.
- `len`  in  LEN_W  number of words to copy; latched on accepted `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on completion.
- `err`  out  1  one-cycle pulse on a rejected command.
- `bus_req`  out  1  bus request to arbiter.
- `bus_gnt`  in  1  bus grant from arbiter.
- `mem_we`  out  1  bus write enable.
- `mem_addr`  out  32  bus byte address.
- `mem_data`  inout  32  shared bus data; driven only in WR, high-Z otherwise.

## Operation
- States: IDLE, REQ, RD, WR, DONE, ERR.
- IDLE + `start`:
  - if `src_addr[1:0]!=0` or `dst_addr[1:0]!=0` -> ERR;
  - else if `len==0` -> DONE;
  - else latch src/dst pointers and count -> REQ.
- `start` outside IDLE is ignored; the command is not queued.
- REQ: `bus_req=1`. If `bus_gnt` -> RD, else stay.
- RD: `bus_req=1`, `mem_we=0`, `mem_addr=src_ptr`, `mem_data` high-Z. At the edge, capture `mem_data` into a 32-bit holding register -> WR.
- WR: `bus_req=1`, `mem_we=1`, `mem_addr=dst_ptr`, `mem_data`=holding register. At the edge: `src_ptr+=4`, `dst_ptr+=4`, `count-=1`.
  - If old count==1 -> DONE.
  - Else if `bus_gnt` -> RD.
  - Else -> REQ.
- `bus_gnt` is sampled only in REQ and WR. The arbiter must not revoke grant between RD and its paired WR.
- DONE: `done=1` for one cycle, then IDLE. ERR: `err=1` for one cycle, then IDLE.
- Outside RD/WR: `mem_we=0`, `mem_addr=0`, `mem_data` high-Z, `bus_req=0` (IDLE, DONE, ERR).
- Pointer arithmetic is 32-bit unsigned and wraps modulo 2^32; no range check in this block.
- Overlapping src/dst regions copy strictly in ascending address order, one word at a time.

## Timing
- Reset values: `busy=0`, `done=0`, `err=0`, `bus_req=0`, `mem_we=0`, `mem_addr=0`, `mem_data` high-Z, state IDLE, pointers/count/holding register 0.
- `rst` mid-transfer: IDLE at the next edge, bus released that cycle, no `done` or `err` pulse. A partially written destination is left as is.
- Outputs are registered state decodes. `mem_data` enable is decoded from state only, so there is no drive overlap with a responder in RD.
- `start` accepted at edge t -> REQ in cycle t+1.
- With `bus_gnt` held high, N words take 2N cycles of RD/WR, and `done` is high in cycle t+2N+2.
- Each grant loss after WR adds at least one REQ cycle per loss.
- `len==0`: `done` in cycle t+1, no bus activity. Misaligned address: `err` in cycle t+1, no bus activity.
- `busy` rises in cycle t+1 and falls in the cycle after the DONE/ERR cycle.

## Test plan
- Copy 4 words 0x000->0x100 with gnt tied high; memory model seeded 0xA0..0xA3 -> destination reads 0xA0..0xA3, `done` at t+10, `mem_we` high exactly 4 cycles.
- Copy 3 words with gnt dropped for 5 cycles after the first WR -> REQ held 5 cycles, data correct, `done` at t+13, `mem_data` high-Z in every non-WR cycle.
- `start` with `len=0` -> `done` at t+1, `bus_req` never asserted. `start` with `src_addr=0x102` -> `err` at t+1, no `done`, no bus cycles.
- `rst` asserted during the second WR of a 4-word copy -> IDLE next cycle, `mem_we=0`, only 1–2 destination words written, no `done`.
- `start` pulsed again while busy, plus `src_addr=0xFFFFFFFC` with `len=2` -> second `start` ignored; reads hit 0xFFFFFFFC then 0x00000000 (wrap).
